// File: rtl/dcache_pkg.sv
// Shared widths, FSM state type and address field helpers for the data cache.
package dcache_pkg;
  localparam int ADDR_W    = 32;
  localparam int WORD_W    = 32;
  localparam int LINE_W    = 256;
  localparam int NUM_LINES = 32;
  localparam int OFFSET_W  = 5;
  localparam int INDEX_W   = 5;
  localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WSEL_W    = 3;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, FILL_DONE} state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return TAG_W'(addr >> (OFFSET_W + INDEX_W));
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return INDEX_W'(addr >> OFFSET_W);
  endfunction

  function automatic logic [WSEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return WSEL_W'(addr >> 2);
  endfunction
endpackage

// File: rtl/dcache_controller_if.sv
// CPU load/store port and memory line port of the data cache.
interface dcache_controller_if;
  import dcache_pkg::*;

  logic [ADDR_W-1:0] cpu_addr_i;
  logic [WORD_W-1:0] cpu_data_i;
  logic              cpu_read_i;
  logic              cpu_write_i;
  logic [WORD_W-1:0] cpu_data_o;
  logic              cpu_stall_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_read_i, cpu_write_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
  );

  modport master (
    output cpu_addr_i, cpu_data_i, cpu_read_i, cpu_write_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
  );
endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and line storage; single index, combinational read, clocked write.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic               we,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_data,
  input  logic               wr_valid,
  input  logic               wr_dirty,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_data
);
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[index] <= wr_valid;
      dirty_q[index] <= wr_dirty;
    end
  end

  // Tag and data need no reset: an entry is meaningless while its valid bit is clear.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[index]  <= wr_tag;
      data_q[index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index];
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller with pipeline stall.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_controller_if.slave  bus
);
  state_t              state, next_state;
  logic [ADDR_W-1:0]   miss_addr;
  logic [INDEX_W-1:0]  idx;
  logic [WSEL_W-1:0]   wsel;
  logic                req, hit;
  logic                rd_valid, rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line, merged_line;
  logic                we, w_valid, w_dirty;
  logic [TAG_W-1:0]    w_tag;
  logic [LINE_W-1:0]   w_line;

  assign req  = bus.cpu_read_i | bus.cpu_write_i;
  // Outside IDLE the latched miss address drives the array, not the live CPU address.
  assign idx  = (state == IDLE) ? addr_index(bus.cpu_addr_i) : addr_index(miss_addr);
  assign wsel = addr_word(bus.cpu_addr_i);
  assign hit  = rd_valid && (rd_tag == addr_tag(bus.cpu_addr_i));

  assign bus.cpu_stall_o = req & ~((state == IDLE) & hit) & ~rst_i;
  assign bus.cpu_data_o  = rd_valid ? rd_line[{wsel, 5'b00000} +: WORD_W] : '0;

  always_comb begin
    merged_line = rd_line;
    merged_line[{wsel, 5'b00000} +: WORD_W] = bus.cpu_data_i;
  end

  dcache_sram u_sram (
    .clk      (clk_i),
    .rst      (rst_i),
    .index    (idx),
    .we       (we),
    .wr_tag   (w_tag),
    .wr_data  (w_line),
    .wr_valid (w_valid),
    .wr_dirty (w_dirty),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_line)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      miss_addr <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && req && !hit) miss_addr <= bus.cpu_addr_i;
    end
  end

  always_comb begin
    next_state       = state;
    we               = 1'b0;
    w_tag            = rd_tag;
    w_line           = rd_line;
    w_valid          = rd_valid;
    w_dirty          = rd_dirty;
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_data_o   = '0;
    unique case (state)
      IDLE: begin
        if (req && hit) begin
          if (bus.cpu_write_i) begin
            we      = 1'b1;
            w_line  = merged_line;
            w_dirty = 1'b1;
          end
        end else if (req) begin
          next_state = (rd_valid && rd_dirty) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {rd_tag, idx, {OFFSET_W{1'b0}}};
        bus.mem_data_o   = rd_line;
        if (bus.mem_ack_i) next_state = FILL;
      end
      FILL: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = {addr_tag(miss_addr), idx, {OFFSET_W{1'b0}}};
        if (bus.mem_ack_i) begin
          we         = 1'b1;
          w_tag      = addr_tag(miss_addr);
          w_line     = bus.mem_data_i;
          w_valid    = 1'b1;
          w_dirty    = 1'b0;
          next_state = FILL_DONE;
        end
      end
      FILL_DONE: next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: table-driven hit vectors plus miss/eviction/reset sequences.
module tb_dcache_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad   = 0;

  dcache_controller_if bus ();

  dcache_controller dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic        exp_stall;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic cpu_drive(input logic [31:0] addr, input logic [31:0] data, input logic rd, input logic wr);
    bus.cpu_addr_i  = addr;
    bus.cpu_data_i  = data;
    bus.cpu_read_i  = rd;
    bus.cpu_write_i = wr;
  endtask

  // One memory phase of lat cycles; ack is pulsed in the last cycle.
  task automatic mem_phase(input string nm, input logic exp_write, input logic [31:0] exp_addr,
                           input logic chk_line, input logic [255:0] exp_line,
                           input int lat, input logic [255:0] line_in);
    int gaps = 0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      bus.mem_ack_i  = (i == lat - 1);
      bus.mem_data_i = line_in;
      #1;
      if (bus.mem_enable_o !== 1'b1) gaps++;
      if (i == 0) begin
        chk({nm, "_write"}, 256'(bus.mem_write_o), 256'(exp_write));
        chk({nm, "_addr"}, 256'(bus.mem_addr_o), 256'(exp_addr));
        if (chk_line) chk({nm, "_line"}, bus.mem_data_o, exp_line);
      end
    end
    chk({nm, "_enable_gaps"}, 256'(gaps), 256'(0));
  endtask

  task automatic run_miss(input string nm, input logic [31:0] addr,
                          input logic exp_wb, input logic [31:0] wb_addr, input logic [255:0] wb_line, input int wb_lat,
                          input logic [31:0] fill_addr, input logic [255:0] fill_line, input int fill_lat,
                          input logic [31:0] exp_word);
    @(negedge clk);
    cpu_drive(addr, 32'h0, 1'b1, 1'b0);
    #1;
    chk({nm, "_req_stall"}, 256'(bus.cpu_stall_o), 256'(1));
    chk({nm, "_req_enable"}, 256'(bus.mem_enable_o), 256'(0));
    if (exp_wb) mem_phase({nm, "_wb"}, 1'b1, wb_addr, 1'b1, wb_line, wb_lat, '0);
    mem_phase({nm, "_fill"}, 1'b0, fill_addr, 1'b0, '0, fill_lat, fill_line);
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    #1;
    chk({nm, "_done_enable"}, 256'(bus.mem_enable_o), 256'(0));
    chk({nm, "_done_stall"}, 256'(bus.cpu_stall_o), 256'(1));
    @(negedge clk);
    #1;
    chk({nm, "_hit_stall"}, 256'(bus.cpu_stall_o), 256'(0));
    chk({nm, "_hit_data"}, 256'(bus.cpu_data_o), 256'(exp_word));
  endtask

  logic [255:0] line1, line2, line3, line4, wb_line;

  initial begin
    line1 = mk_line(32'h1000_0000);
    line1[95:64] = 32'hDEAD_BEEF;
    line2 = mk_line(32'h2000_0000);
    line3 = mk_line(32'h3000_0000);
    line4 = mk_line(32'h4000_0000);
    wb_line = line1;
    wb_line[63:32] = 32'h1234_5678;
    wb_line[95:64] = 32'hA5A5_A5A5;

    vecs[0] = '{32'h44, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{32'h44, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_5678};
    vecs[2] = '{32'h48, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{32'h40, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0000};
    vecs[4] = '{32'h48, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{32'h48, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5};
    vecs[6] = '{32'h5C, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0007};
    vecs[7] = '{32'h43, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0000};
    vecs[8] = '{32'h444, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    cpu_drive(32'h0, 32'h0, 1'b0, 1'b0);
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 256'(bus.cpu_stall_o), 256'(0));
    chk("rst_enable", 256'(bus.mem_enable_o), 256'(0));
    chk("rst_write", 256'(bus.mem_write_o), 256'(0));
    chk("rst_addr", 256'(bus.mem_addr_o), 256'(0));
    chk("rst_mdata", bus.mem_data_o, '0);
    chk("rst_cdata", 256'(bus.cpu_data_o), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    run_miss("cold", 32'h48, 1'b0, 32'h0, '0, 0, 32'h40, line1, 10, 32'hDEAD_BEEF);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cpu_drive(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr);
      #1;
      chk($sformatf("vec%0d_stall", i), 256'(bus.cpu_stall_o), 256'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_enable", i), 256'(bus.mem_enable_o), 256'(0));
      if (vecs[i].chk_data)
        chk($sformatf("vec%0d_data", i), 256'(bus.cpu_data_o), 256'(vecs[i].exp_data));
    end

    run_miss("dirty", 32'h444, 1'b1, 32'h40, wb_line, 3, 32'h440, line2, 4, 32'h2000_0001);
    run_miss("clean", 32'h840, 1'b0, 32'h0, '0, 0, 32'h840, line3, 1, 32'h3000_0000);

    // Reset in the middle of a fill that memory has not acknowledged.
    @(negedge clk);
    cpu_drive(32'h1040, 32'h0, 1'b1, 1'b0);
    #1;
    chk("rmid_req_stall", 256'(bus.cpu_stall_o), 256'(1));
    @(negedge clk);
    #1;
    chk("rmid_fill_enable", 256'(bus.mem_enable_o), 256'(1));
    chk("rmid_fill_addr", 256'(bus.mem_addr_o), 256'(32'h1040));
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rmid_enable", 256'(bus.mem_enable_o), 256'(0));
    chk("rmid_stall", 256'(bus.cpu_stall_o), 256'(0));
    chk("rmid_addr", 256'(bus.mem_addr_o), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    cpu_drive(32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rmid_idle_stall", 256'(bus.cpu_stall_o), 256'(0));
    run_miss("post_rst", 32'h1040, 1'b0, 32'h0, '0, 0, 32'h1040, line4, 2, 32'h4000_0000);

    @(negedge clk);
    cpu_drive(32'h0, 32'h0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
